// File: rtl/uart_pkt_dispatch.sv
// uart_pkt_dispatch: parses a 4-byte header and grants one engine per packet.
// Optional idle timeout in HDR1..HDR3/DRAIN: define UART_DISPATCH_TIMEOUT_EN.
module uart_pkt_dispatch #(
  parameter int num_eng_p = 3,
  parameter int timeout_p = 65535
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_valid_i,
  output logic                 rx_ready_o,
  output logic [7:0]           eng_data_o,
  output logic [num_eng_p-1:0] eng_valid_o,
  input  logic [num_eng_p-1:0] eng_ready_i,
  output logic [num_eng_p-1:0] eng_start_o,
  input  logic [num_eng_p-1:0] eng_done_i,
  output logic [15:0]          len_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o
);

  localparam int SW = (num_eng_p > 1) ? $clog2(num_eng_p) : 1;
  localparam logic [7:0] MAX_OP = 8'(num_eng_p);

  typedef enum logic [2:0] {
    HDR0, HDR1, HDR2, HDR3, PAYLOAD, DRAIN, WAIT_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           op_q, op_d;
  logic [7:0]           lsb_q, lsb_d;
  logic [15:0]          rem_q, rem_d;
  logic [15:0]          len_q, len_d;
  logic [SW-1:0]        sel_q, sel_d;
  logic [num_eng_p-1:0] start_q, start_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;
  logic [num_eng_p-1:0] sel_oh, op_oh, valid_c;
  logic                 ready_c, xfer, op_ok;
  logic [15:0]          hdr_len;

  assign hdr_len = {rx_data_i, lsb_q};
  assign op_ok   = (op_q != 8'd0) && (op_q <= MAX_OP);

  always_comb begin
    sel_oh = '0;
    op_oh  = '0;
    for (int k = 0; k < num_eng_p; k++) begin
      sel_oh[k] = (sel_q == SW'(k));
      op_oh[k]  = (op_q == 8'(k + 1));
    end
  end

  always_comb begin
    ready_c = 1'b0;
    valid_c = '0;
    unique case (state_q)
      HDR0, HDR1, HDR2, HDR3, DRAIN: ready_c = 1'b1;
      PAYLOAD: begin
        ready_c = eng_ready_i[sel_q];
        valid_c = sel_oh & {num_eng_p{rx_valid_i}};
      end
      default: ready_c = 1'b0;
    endcase
  end

  // Ready/valid are forced low while reset is held.
  assign rx_ready_o  = rst_ni & ready_c;
  assign eng_valid_o = rst_ni ? valid_c : '0;
  assign xfer        = rx_valid_i & rx_ready_o;

`ifdef UART_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(timeout_p + 1);
  logic [TW-1:0] idle_q, idle_d;
  logic          timed;
  assign timed = (state_q == HDR1) || (state_q == HDR2) ||
                 (state_q == HDR3) || (state_q == DRAIN);
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    lsb_d   = lsb_q;
    rem_d   = rem_q;
    len_d   = len_q;
    sel_d   = sel_q;
    start_d = '0;
    err_d   = 1'b0;
    code_d  = code_q;
    unique case (state_q)
      HDR0: if (xfer) begin
        op_d    = rx_data_i;
        state_d = HDR1;
      end
      HDR1: if (xfer) state_d = HDR2;
      HDR2: if (xfer) begin
        lsb_d   = rx_data_i;
        state_d = HDR3;
      end
      HDR3: if (xfer) begin
        if (hdr_len < 16'd4) begin
          err_d   = 1'b1;
          code_d  = 2'd2;
          state_d = HDR0;
        end else if (!op_ok) begin
          err_d   = 1'b1;
          code_d  = 2'd1;
          rem_d   = hdr_len - 16'd4;
          state_d = (hdr_len == 16'd4) ? HDR0 : DRAIN;
        end else begin
          len_d   = hdr_len;
          sel_d   = SW'(op_q - 8'd1);
          rem_d   = hdr_len - 16'd4;
          start_d = op_oh;
          state_d = (hdr_len == 16'd4) ? WAIT_DONE : PAYLOAD;
        end
      end
      PAYLOAD: if (xfer) begin
        rem_d = rem_q - 16'd1;
        if (rem_q == 16'd1) state_d = WAIT_DONE;
      end
      DRAIN: if (xfer) begin
        rem_d = rem_q - 16'd1;
        if (rem_q == 16'd1) state_d = HDR0;
      end
      WAIT_DONE: if (eng_done_i[sel_q]) state_d = HDR0;
      default: state_d = HDR0;
    endcase
`ifdef UART_DISPATCH_TIMEOUT_EN
    idle_d = '0;
    if (timed && !xfer) begin
      if (idle_q == TW'(timeout_p - 1)) begin
        err_d   = 1'b1;
        code_d  = 2'd3;
        state_d = HDR0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HDR0;
      op_q    <= '0;
      lsb_q   <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      sel_q   <= '0;
      start_q <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lsb_q   <= lsb_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

`ifdef UART_DISPATCH_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idle_q <= '0;
    else         idle_q <= idle_d;
  end
`endif

  assign eng_data_o  = rx_data_i;
  assign eng_start_o = start_q;
  assign len_o       = len_q;
  assign busy_o      = (state_q != HDR0);
  assign err_o       = err_q;
  assign err_code_o  = code_q;

endmodule
